uart_tx_arbiter: RTL

//  Shares one uart transmitter (i_data/i_tx_enable/o_tx_rdy/o_tx_done side) between NREQ byte-stream

---
 rtl/uart_tx_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between NREQ byte-stream
// requesters. Round-robin grant held for a whole packet (i_last or MAX_BURST
// bytes), one byte in flight at a time, stalled owners revoked after TIMEOUT.
module uart_tx_arbiter #(
    parameter int NREQ      = 2,
    parameter int D_BITS    = 8,
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 1024
) (
    input  logic                   i_clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        i_valid,
    input  logic [NREQ*D_BITS-1:0] i_data,
    input  logic [NREQ-1:0]        i_last,
    output logic [NREQ-1:0]        o_ready,
    output logic [NREQ-1:0]        o_grant,
    output logic [D_BITS-1:0]      o_tx_data,
    output logic                   o_tx_enable,
    input  logic                   i_tx_rdy,
    input  logic                   i_tx_done,
    output logic                   o_busy,
    output logic                   o_timeout
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam int STL_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NREQ - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);
    // Last stalled cycle before revocation: counter value TIMEOUT-1 plus one more stall.
    localparam logic [STL_W-1:0] STL_LAST = STL_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        WAIT = 2'd3
    } state_t;

    state_t            state, state_d;
    logic [PTR_W-1:0]  ptr, ptr_d;
    logic [PTR_W-1:0]  gidx, gidx_d;
    logic [PTR_W-1:0]  gnext;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [STL_W-1:0]  stall, stall_d;
    logic [D_BITS-1:0] tx_data_d;
    logic              last_q, last_d;
    logic              timeout_d;

    logic              found;
    logic [PTR_W-1:0]  pick;
    logic [NREQ-1:0]   grant_vec;
    logic              sel_valid;
    logic              sel_last;
    logic [D_BITS-1:0] sel_data;

    // Round-robin pick: lowest valid index at or above ptr, else lowest valid index overall.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
        found = |i_valid;
        pick  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (i_valid[k]) pick = PTR_W'(k);
        end
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (i_valid[k] && (PTR_W'(k) >= ptr)) pick = PTR_W'(k);
        end
    end

    // Decode the registered grant index into a one-hot vector and mux the owner's inputs.
    always_comb begin
        grant_vec = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gidx == PTR_W'(k)) begin
                grant_vec[k] = 1'b1;
                sel_valid    = i_valid[k];
                sel_last     = i_last[k];
                sel_data     = i_data[k*D_BITS +: D_BITS];
            end
        end
    end

    assign gnext = (gidx == PTR_LAST) ? '0 : gidx + 1'b1;

    // Next-state and output decode for the ARB -> LOAD -> SEND -> WAIT sequence.
    always_comb begin
        state_d     = state;
        ptr_d       = ptr;
        gidx_d      = gidx;
        cnt_d       = cnt;
        stall_d     = stall;
        tx_data_d   = o_tx_data;
        last_d      = last_q;
        timeout_d   = 1'b0;
        o_ready     = '0;
        o_grant     = grant_vec;
        o_tx_enable = 1'b0;
        o_busy      = 1'b1;

        unique case (state)
            ARB: begin
                o_grant = '0;
                o_busy  = 1'b0;
                if (found) begin
                    gidx_d  = pick;
                    cnt_d   = '0;
                    stall_d = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (i_tx_rdy) o_ready = grant_vec;
                if (sel_valid && i_tx_rdy) begin
                    tx_data_d = sel_data;
                    last_d    = sel_last;
                    cnt_d     = cnt + 1'b1;
                    state_d   = SEND;
                end else if ((TIMEOUT != 0) && (stall == STL_LAST)) begin
                    // Owner stalled too long: revoke and let the next requester in.
                    timeout_d = 1'b1;
                    ptr_d     = gnext;
                    state_d   = ARB;
                end else begin
                    stall_d = stall + 1'b1;
                end
            end
            SEND: begin
                o_tx_enable = 1'b1;
                state_d     = WAIT;
            end
            WAIT: begin
                if (i_tx_done) begin
                    if (last_q || (cnt == CNT_MAX)) begin
                        ptr_d   = gnext;
                        state_d = ARB;
                    end else begin
                        stall_d = '0;
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    // State and datapath registers with synchronous reset; a reset mid-frame simply drops the byte.
    always_ff @(posedge i_clk) begin
        // NOTE: registers use non-blocking assignments so each one updates from pre-edge values regardless of statement order.
        if (reset) begin
            state     <= ARB;
            ptr       <= '0;
            gidx      <= '0;
            cnt       <= '0;
            stall     <= '0;
            o_tx_data <= '0;
            last_q    <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            gidx      <= gidx_d;
            cnt       <= cnt_d;
            stall     <= stall_d;
            o_tx_data <= tx_data_d;
            last_q    <= last_d;
            o_timeout <= timeout_d;
        end
    end

endmodule
